// File: rtl/puf_serializer.sv
// puf_serializer: valid/ready loaded PISO that shifts a PUF response out MSB-first, BIT_CYCLES clocks per bit.
// Optional trailing even-parity bit when PUF_SER_PARITY_EN is defined.
module puf_serializer #(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last,
  output logic             busy
);
  localparam int BW = $clog2(WIDTH);
  localparam int DW = $clog2(BIT_CYCLES + 1);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
`ifdef PUF_SER_PARITY_EN
  localparam logic [1:0] S_PARITY = 2'd2;
  logic r_par;
`endif
  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_shift;
  logic [BW-1:0]    r_bit;
  logic [DW-1:0]    r_div;
  logic             w_div_done;
  logic             w_last_bit;
  logic             w_xfer;
  assign w_div_done = r_div == DW'(BIT_CYCLES - 1);
  assign w_last_bit = r_bit == BW'(WIDTH - 1);
  assign busy       = r_state != S_IDLE;
  assign sout_valid = busy;
`ifdef PUF_SER_PARITY_EN
  assign sout_last  = r_state == S_PARITY;
  assign sout       = (r_state == S_SHIFT && r_shift[WIDTH-1]) || (r_state == S_PARITY && r_par);
`else
  assign sout_last  = r_state == S_SHIFT && w_last_bit;
  assign sout       = r_state == S_SHIFT && r_shift[WIDTH-1];
`endif
  // Ready opens in the last cycle of the frame so a new word follows without a gap.
  assign load_ready = r_state == S_IDLE || (sout_last && w_div_done);
  assign w_xfer     = load_valid && load_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_bit   <= '0;
      r_div   <= '0;
`ifdef PUF_SER_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else if (w_xfer) begin
      r_state <= S_SHIFT;
      r_shift <= load_data;
      r_bit   <= '0;
      r_div   <= '0;
`ifdef PUF_SER_PARITY_EN
      r_par   <= ^load_data;
`endif
    end else if (r_state != S_IDLE) begin
      if (!w_div_done) begin
        r_div <= r_div + DW'(1);
      end else begin
        r_div <= '0;
        if (r_state == S_SHIFT && !w_last_bit) begin
          r_shift <= r_shift << 1;
          r_bit   <= r_bit + BW'(1);
        end
`ifdef PUF_SER_PARITY_EN
        else if (r_state == S_SHIFT) begin
          r_state <= S_PARITY;
        end
`endif
        else begin
          r_state <= S_IDLE;
          r_bit   <= '0;
          r_shift <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_puf_serializer.sv
// tb_puf_serializer: drives two serializers (BIT_CYCLES 1 and 3) and compares every cycle
// against an expected-bit queue built from each accepted word.
module tb_puf_serializer;
  logic       clk;
  logic       rst_n;
  logic [7:0] data;
  logic       valid;
  bit         sel;
  logic       v1, v3;
  logic       r1, s1, sv1, sl1, b1;
  logic       r3, s3, sv3, sl3, b3;
  logic       d_ready, d_sout, d_valid, d_last, d_busy;
  logic [1:0] q[$];
  logic [7:0] rx;
  int         checks;
  int         failures;
  int         n;

  assign v1 = valid && !sel;
  assign v3 = valid && sel;

  puf_serializer #(.WIDTH(8), .BIT_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .load_data(data), .load_valid(v1), .load_ready(r1),
    .sout(s1), .sout_valid(sv1), .sout_last(sl1), .busy(b1));

  puf_serializer #(.WIDTH(8), .BIT_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .load_data(data), .load_valid(v3), .load_ready(r3),
    .sout(s3), .sout_valid(sv3), .sout_last(sl3), .busy(b3));

  always_comb begin
    d_ready = sel ? r3 : r1;
    d_sout  = sel ? s3 : s1;
    d_valid = sel ? sv3 : sv1;
    d_last  = sel ? sl3 : sl1;
    d_busy  = sel ? b3 : b1;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Each frame bit is held BIT_CYCLES entries; last flag marks the closing bit.
  task automatic push_frame(input logic [7:0] w);
    int bc;
    bit par_en;
    bc = sel ? 3 : 1;
`ifdef PUF_SER_PARITY_EN
    par_en = 1;
`else
    par_en = 0;
`endif
    for (int i = 7; i >= 0; i--)
      repeat (bc) q.push_back({w[i], (i == 0) && !par_en});
    if (par_en)
      repeat (bc) q.push_back({^w, 1'b1});
  endtask

  task automatic tick();
    logic [1:0] e;
    bit xfer;
    e = (q.size() != 0) ? q[0] : 2'b00;
    chk("sout", 32'(d_sout), 32'(e[1]));
    chk("sout_valid", 32'(d_valid), 32'(q.size() != 0));
    chk("sout_last", 32'(d_last), 32'(e[0]));
    chk("busy", 32'(d_busy), 32'(q.size() != 0));
    chk("load_ready", 32'(d_ready), 32'(q.size() <= 1));
    if (!sel && d_valid) rx = {rx[6:0], d_sout};
    xfer = valid && (q.size() <= 1);
    @(posedge clk);
    if (q.size() != 0) void'(q.pop_front());
    if (xfer) push_frame(data);
    #1;
  endtask

  task automatic idle(input int c);
    repeat (c) tick();
  endtask

  task automatic send(input logic [7:0] w, output int cnt);
    bit acc;
    cnt = 0;
    valid = 1'b1;
    data = w;
    do begin
      acc = q.size() <= 1;
      tick();
      cnt++;
    end while (!acc && cnt < 200);
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout word=%0h", w);
    end
    valid = 1'b0;
    data = 8'($urandom);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_sout", 32'(d_sout), 0);
    chk("rst_valid", 32'(d_valid), 0);
    chk("rst_last", 32'(d_last), 0);
    chk("rst_busy", 32'(d_busy), 0);
    q.delete();
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b1;
    valid = 1'b0;
    data = 8'h00;
    sel = 1'b0;
    rx = 8'h00;
    @(posedge clk);
    #1;
    do_reset();
    idle(2);
    send(8'hA5, n);
    chk("first_accept", 32'(n), 1);
    idle(10);
`ifndef PUF_SER_PARITY_EN
    chk("capture_A5", 32'(rx), 32'hA5);
`endif
    send(8'hA5, n);
    send(8'h3C, n);
`ifdef PUF_SER_PARITY_EN
    chk("b2b_wait", 32'(n), 9);
`else
    chk("b2b_wait", 32'(n), 8);
`endif
    idle(20);
    send(8'h0F, n);
    idle(1);
    send(8'hFF, n);
`ifdef PUF_SER_PARITY_EN
    chk("reject_wait", 32'(n), 8);
`else
    chk("reject_wait", 32'(n), 7);
`endif
    idle(12);
    send(8'hFF, n);
    idle(3);
    do_reset();
    send(8'h01, n);
    chk("post_reset_accept", 32'(n), 1);
    idle(10);
    send(8'h07, n);
    idle(11);
    for (int k = 0; k < 20; k++) begin
      send(8'($urandom), n);
      idle($urandom_range(0, 2));
    end
    idle(12);
    sel = 1'b1;
    send(8'h81, n);
    idle(30);
    for (int k = 0; k < 10; k++) begin
      send(8'($urandom), n);
      idle($urandom_range(0, 4));
    end
    idle(30);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
